// File: rtl/pio_edge_irq_pkg.sv
// Shared constants for the edge-capturing input PIO: register addresses and
// edge-type encodings.
package pio_edge_irq_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain followed by an optional debounce filter
// producing the accepted (stable) level.
module pio_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable = sync_out;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          stable_q;

            // Accept on the DEBOUNCE_CYCLES-th consecutive differing cycle;
            // the counter never climbs past CNT_LAST, so it cannot wrap.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt      <= '0;
                    stable_q <= 1'b0;
                end else if (sync_out == stable_q) begin
                    cnt <= '0;
                end else if (cnt >= CNT_LAST) begin
                    cnt      <= '0;
                    stable_q <= sync_out;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign stable = stable_q;
        end
    endgenerate

endmodule

// File: rtl/pio_edge_irq_in.sv
// Avalon-MM input PIO with synchronised/debounced inputs, edge capture with
// write-1-to-clear, and a masked level interrupt.
module pio_edge_irq_in
    import pio_edge_irq_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .in_bit (in_port[i]),
            .stable (stable[i])
        );
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

    always_comb begin
        edge_det = rise;
        if (EDGE_TYPE == int'(EDGE_FALL)) begin
            edge_det = fall;
        end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
            edge_det = rise | fall;
        end
    end

    assign wr_en        = chipselect & ~write_n;
    assign clr          = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux = 32'(stable);
            ADDR_MASK: rd_mux = 32'(irq_mask);
            ADDR_EDGE: rd_mux = 32'(edge_cap);
            default:   rd_mux = '0;
        endcase
    end

    // A new edge is OR-ed in after the clear so it survives a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            stable_d <= stable;
            if (wr_en && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_cap <= (edge_cap & ~clr) | edge_det;
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule
